// File: rtl/crc_frame_chk.sv
// crc_frame_chk: streaming CRC frame checker with a registered pass/fail result handshake and saturating stats
module crc_frame_chk #(
  parameter int DATA_W = 8,
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT = CRC_W'(16'hFFFF),
  parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(16'h0000),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sop_i,
  input  logic              in_eop_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_ok_o,
  output logic [CRC_W-1:0]  out_crc_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state_q;
  logic [CRC_W-1:0] crc_q, crc_d, out_crc_q;
  logic out_valid_q, out_ok_q, acc, drop, take;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q, drop_cnt_q;
  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c, input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) r = (r << 1) ^ ((r[CRC_W-1] ^ d[i]) ? POLY : '0);
    return r;
  endfunction
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return &c ? c : c + CNT_W'(1);
  endfunction
  assign in_ready_o = state_q != HOLD && !rst;
  // a beat either feeds the CRC (take) or is counted as a drop; a mid-frame sop does both
  always_comb begin
    acc = in_valid_i & in_ready_o;
    drop = acc & (state_q == IDLE ? !in_sop_i : in_sop_i);
    take = acc & (in_sop_i | state_q == RUN);
    crc_d = crc_next(in_sop_i ? INIT : crc_q, in_data_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q <= INIT;
      out_valid_q <= 1'b0;
      out_ok_q <= 1'b0;
      out_crc_q <= '0;
      frame_cnt_q <= '0;
      err_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (drop) drop_cnt_q <= sat(drop_cnt_q);
      if (state_q == HOLD && out_ready_i) begin
        out_valid_q <= 1'b0;
        state_q <= IDLE;
      end
      if (take) begin
        crc_q <= crc_d;
        state_q <= in_eop_i ? HOLD : RUN;
        if (in_eop_i) begin
          out_valid_q <= 1'b1;
          out_crc_q <= crc_d;
          out_ok_q <= crc_d == RESIDUE;
          frame_cnt_q <= sat(frame_cnt_q);
          if (crc_d != RESIDUE) err_cnt_q <= sat(err_cnt_q);
        end
      end
    end
  end
  assign out_valid_o = out_valid_q;
  assign out_ok_o = out_ok_q;
  assign out_crc_o = out_crc_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o = err_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_crc_frame_chk.sv
// tb_crc_frame_chk: randomized frame stream checked against a polynomial-division reference model
module tb_crc_frame_chk;
  localparam int CMAX = 15;
  logic clk = 0, rst = 1, in_valid = 0, in_sop = 0, in_eop = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, out_ok;
  logic [15:0] out_crc;
  logic [3:0] frame_cnt, err_cnt, drop_cnt;
  logic w_valid = 0, w_sop = 0, w_eop = 0, w_oready = 0;
  logic [15:0] w_data = 0;
  logic w_ready, w_ovalid, w_ok;
  logic [15:0] w_crc, w_fc, w_ec, w_dc;
  int n_vec = 0, n_err = 0, e_frame = 0, e_err = 0, e_drop = 0, force_hold = -1, exp_fix = -1;
  bit in_frame = 0;
  bit msg[$];
  logic [7:0] fr[$];
  crc_frame_chk #(.CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_sop_i(in_sop), .in_eop_i(in_eop), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ok_o(out_ok), .out_crc_o(out_crc), .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt),
    .drop_cnt_o(drop_cnt)
  );
  crc_frame_chk #(.DATA_W(16), .INIT(16'h0000)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid_i(w_valid), .in_ready_o(w_ready), .in_data_i(w_data),
    .in_sop_i(w_sop), .in_eop_i(w_eop), .out_valid_o(w_ovalid), .out_ready_i(w_oready),
    .out_ok_o(w_ok), .out_crc_o(w_crc), .frame_cnt_o(w_fc), .err_cnt_o(w_ec), .drop_cnt_o(w_dc)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // remainder of (INIT*x^N + M*x^16) mod G by long division over the message bits
  function automatic logic [15:0] ref_crc(input logic [15:0] init);
    bit d[$];
    logic [16:0] p = 17'h11021;
    logic [15:0] r;
    int n = msg.size();
    for (int k = 0; k < n + 16; k++) d.push_back((k < n ? msg[k] : 1'b0) ^ (k < 16 ? init[15-k] : 1'b0));
    for (int k = 0; k < n; k++)
      if (d[k]) for (int j = 0; j <= 16; j++) d[k+j] = d[k+j] ^ p[16-j];
    for (int j = 0; j < 16; j++) r[15-j] = d[n+j];
    return r;
  endfunction
  function automatic int sat(input int c);
    return c == CMAX ? c : c + 1;
  endfunction
  function automatic logic [15:0] crc_of_fr();
    msg.delete();
    foreach (fr[i]) for (int b = 7; b >= 0; b--) msg.push_back(fr[i][b]);
    return ref_crc(16'hFFFF);
  endfunction
  task automatic consume();
    logic [15:0] e;
    int hold;
    e = ref_crc(16'hFFFF);
    e_frame = sat(e_frame);
    if (e != 0) e_err = sat(e_err);
    hold = force_hold >= 0 ? force_hold : int'($urandom_range(0, 3));
    chk("lat_valid", out_valid, 1);
    chk("crc", out_crc, e);
    chk("ok", out_ok, e == 0);
    chk("frame_cnt", frame_cnt, e_frame);
    chk("err_cnt", err_cnt, e_err);
    if (exp_fix >= 0) chk("fixed_crc", out_crc, exp_fix);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_sop = 1'($urandom); in_eop = 1'($urandom); in_data = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_crc", out_crc, e);
      chk("hold_ok", out_ok, e == 0);
      chk("hold_ready", in_ready, 0);
      chk("hold_drop", drop_cnt, e_drop);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("rel_valid", out_valid, 0);
    chk("rel_ready", in_ready, 1);
  endtask
  task automatic send(input logic [7:0] d, input bit sop, input bit eop);
    int t = 0;
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 0; in_sop = 1'($urandom); in_eop = 1'($urandom); in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1; in_sop = sop; in_eop = eop; in_data = d;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(negedge clk);
    in_valid = 0; in_sop = 0; in_eop = 0;
    if (sop) begin
      if (in_frame) e_drop = sat(e_drop);
      msg.delete();
      in_frame = 1;
    end else if (!in_frame) e_drop = sat(e_drop);
    if (in_frame) for (int b = 7; b >= 0; b--) msg.push_back(d[b]);
    chk("drop_cnt", drop_cnt, e_drop);
    if (eop && in_frame) begin
      in_frame = 0;
      consume();
    end
  endtask
  task automatic send_fr();
    foreach (fr[i]) send(fr[i], i == 0, i == fr.size() - 1);
  endtask
  task automatic rand_fr(input bit bad);
    logic [15:0] c;
    fr.delete();
    repeat ($urandom_range(1, 6)) fr.push_back(8'($urandom));
    c = crc_of_fr() ^ (bad ? 16'(1 << $urandom_range(0, 15)) : 16'h0);
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
  endtask
  initial begin
    logic [15:0] e;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ok", out_ok, 0);
    chk("rst_crc", out_crc, 0);
    chk("rst_cnts", {frame_cnt, err_cnt, drop_cnt}, 0);
    chk("rst_ready16", w_ready, 0);
    rst = 0;
    @(negedge clk);
    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    exp_fix = 0;
    send_fr();
    exp_fix = -1;
    chk("t1_frame", frame_cnt, 1);
    fr[10] = 8'hB0;
    force_hold = 5;
    send_fr();
    force_hold = -1;
    chk("t2_err", err_cnt, 1);
    repeat (3) send(8'($urandom), 0, 1'($urandom));
    send(8'($urandom), 1, 0);
    send(8'($urandom), 0, 0);
    rand_fr(0);
    send_fr();
    chk("t4_drop", drop_cnt, 4);
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom), 0, 1'($urandom));
      rand_fr(1'($urandom));
      if ($urandom_range(0, 3) == 0) send(8'($urandom), 1, 0);
      send_fr();
    end
    repeat (16) send(8'($urandom), 0, 0);
    for (int n = 0; n < 16; n++) begin
      rand_fr(1);
      send_fr();
    end
    chk("sat_frame", frame_cnt, CMAX);
    chk("sat_err", err_cnt, CMAX);
    chk("sat_drop", drop_cnt, CMAX);
    send(8'($urandom), 1, 0);
    send(8'($urandom), 0, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    in_frame = 0; e_frame = 0; e_err = 0; e_drop = 0;
    chk("mid_rst_cnts", {frame_cnt, err_cnt, drop_cnt}, 0);
    chk("mid_rst_out", {out_valid, out_ok, out_crc}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_nores", out_valid, 0);
    end
    send(8'($urandom), 0, 1);
    chk("mid_rst_frame", frame_cnt, 0);
    for (int n = 0; n < 5; n++) begin
      w_data = n == 0 ? 16'h0000 : 16'($urandom);
      msg.delete();
      for (int b = 15; b >= 0; b--) msg.push_back(w_data[b]);
      e = ref_crc(16'h0000);
      w_valid = 1; w_sop = 1; w_eop = 1;
      @(negedge clk);
      w_valid = 0;
      chk("w_valid", w_ovalid, 1);
      chk("w_ok", w_ok, e == 0);
      chk("w_crc", w_crc, e);
      chk("w_frame", w_fc, n + 1);
      w_oready = 1;
      @(negedge clk);
      w_oready = 0;
      chk("w_rel", w_ovalid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
